// File: rtl/split_pkg.sv
// rtl/split_pkg.sv - shared types and helpers for lane split/merge blocks
// Contents: state_t (IDLE, SHIFT), clog2(), lane_count() clamp.
package split_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width needed to encode values 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A requested lane count of 0, or one larger than the word holds,
    // means "send the whole word".
    function automatic int lane_count(input int req, input int lanes);
        if (req <= 0 || req > lanes) return lanes;
        return req;
    endfunction

endpackage

// File: rtl/split_lane_sel.sv
// rtl/split_lane_sel.sv - combinational LANES:1 lane multiplexer
// Ports: word (LANES*LANE_W packed lanes, lane 0 in the low bits),
//        sel (physical lane index), lane (selected lane, 0 if sel is out of range).
module split_lane_sel
    import split_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int SEL_W  = clog2(LANES)
) (
    input  logic [LANES*LANE_W-1:0] word,
    input  logic [SEL_W-1:0]        sel,
    output logic [LANE_W-1:0]       lane
);

    // Compare-and-select keeps non-power-of-two LANES from indexing past the word.
    always_comb begin
        lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sel == SEL_W'(i)) lane = word[i*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/split_serial.sv
// rtl/split_serial.sv - wide word to narrow lane-per-beat serialiser
// Ports: clk, rst (async active-high); in_data/in_lanes/in_valid/in_ready word input;
//        out_data/out_idx/out_last/out_valid/out_ready lane stream; busy while a word is held.
module split_serial
    import split_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int LANE_W    = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = clog2(LANES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [CNT_W-1:0]        in_lanes,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [LANE_W-1:0]       out_data,
    output logic [CNT_W-1:0]        out_idx,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int SEL_W = clog2(LANES);

    state_t                  state_q, state_d;
    logic [LANES*LANE_W-1:0] word_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        beat_q;
    logic [CNT_W-1:0]        phys_idx;
    logic [LANE_W-1:0]       lane;
    logic                    last_beat;
    logic                    accept;
    logic                    xfer;

    // Beat number maps to a physical lane; descending order counts down from the top lane.
    always_comb begin
        if (MSB_FIRST) phys_idx = CNT_W'(LANES - 1) - beat_q;
        else           phys_idx = beat_q;
    end

    assign last_beat = (beat_q == count_q - CNT_W'(1));
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    split_lane_sel #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .SEL_W  (SEL_W)
    ) u_lane_sel (
        .word (word_q),
        .sel  (phys_idx[SEL_W-1:0]),
        .lane (lane)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Outputs are gated by state so that IDLE presents all-zero beat fields.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = last_beat;
                out_data  = lane;
                out_idx   = phys_idx;
                // The final beat leaving frees the word register for a same-cycle refill.
                if (out_ready && last_beat) begin
                    in_ready = 1'b1;
                    if (!in_valid) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            count_q <= '0;
            beat_q  <= '0;
        end else if (accept) begin
            word_q  <= in_data;
            count_q <= CNT_W'(lane_count(int'(in_lanes), LANES));
            beat_q  <= '0;
        end else if (xfer) begin
            beat_q  <= beat_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_split_serial.sv
// tb/tb_split_serial.sv - scoreboard bench for split_serial, both lane orders
module tb_split_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [2:0]  in_lanes;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready0, out_last0, out_valid0, busy0;
    logic [7:0]  out_data0;
    logic [2:0]  out_idx0;
    logic        in_ready1, out_last1, out_valid1, busy1;
    logic [7:0]  out_data1;
    logic [2:0]  out_idx1;

    always #5 clk = ~clk;

    split_serial #(.LANES(4), .LANE_W(8), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_lanes(in_lanes),
        .in_valid(in_valid), .in_ready(in_ready0), .out_data(out_data0),
        .out_idx(out_idx0), .out_last(out_last0), .out_valid(out_valid0),
        .out_ready(out_ready), .busy(busy0)
    );

    split_serial #(.LANES(4), .LANE_W(8), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_lanes(in_lanes),
        .in_valid(in_valid), .in_ready(in_ready1), .out_data(out_data1),
        .out_idx(out_idx1), .out_last(out_last1), .out_valid(out_valid1),
        .out_ready(out_ready), .busy(busy1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t e0, e1;
    int    nvec = 0;
    int    nerr = 0;
    bit    rdy_mode = 1'b0;
    bit    stall0 = 1'b0, stall1 = 1'b0;
    logic [11:0] hold0, hold1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word yields n lanes (0 or >4 means 4), in ascending
    // lane order, or for descending order the top n lanes from lane 3 down.
    function automatic int model_cnt(input int n);
        return (n == 0 || n > 4) ? 4 : n;
    endfunction

    function automatic beat_t model_beat(input logic [31:0] w, input int n, input bit msb, input int k);
        beat_t b;
        int    lane;
        lane   = msb ? 3 - k : k;
        b.d    = 8'((w >> (8 * lane)) & 32'hff);
        b.idx  = 3'(lane);
        b.last = (k == model_cnt(n) - 1);
        return b;
    endfunction

    // Monitor: samples on the falling edge, when all handshake signals are settled.
    always @(negedge clk) begin
        if (rst) begin
            stall0 = 1'b0;
            stall1 = 1'b0;
        end else begin
            if (stall0 && out_valid0) chk("dut0_stall_hold", 32'({out_data0, out_idx0, out_last0}), 32'(hold0));
            if (stall1 && out_valid1) chk("dut1_stall_hold", 32'({out_data1, out_idx1, out_last1}), 32'(hold1));
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) chk("dut0_unexpected_beat", 32'(out_data0), 32'hffff_ffff);
                else begin
                    e0 = q0.pop_front();
                    chk("dut0_data", 32'(out_data0), 32'(e0.d));
                    chk("dut0_idx",  32'(out_idx0),  32'(e0.idx));
                    chk("dut0_last", 32'(out_last0), 32'(e0.last));
                end
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) chk("dut1_unexpected_beat", 32'(out_data1), 32'hffff_ffff);
                else begin
                    e1 = q1.pop_front();
                    chk("dut1_data", 32'(out_data1), 32'(e1.d));
                    chk("dut1_idx",  32'(out_idx1),  32'(e1.idx));
                    chk("dut1_last", 32'(out_last1), 32'(e1.last));
                end
            end
            stall0 = out_valid0 && !out_ready;
            stall1 = out_valid1 && !out_ready;
            hold0  = {out_data0, out_idx0, out_last0};
            hold1  = {out_data1, out_idx1, out_last1};
            if (in_valid && in_ready0) begin
                for (int k = 0; k < model_cnt(int'(in_lanes)); k++)
                    q0.push_back(model_beat(in_data, int'(in_lanes), 1'b0, k));
            end
            if (in_valid && in_ready1) begin
                for (int k = 0; k < model_cnt(int'(in_lanes)); k++)
                    q1.push_back(model_beat(in_data, int'(in_lanes), 1'b1, k));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Presents a word and returns just after the edge that accepted it.
    task automatic put_word(input logic [31:0] d, input logic [2:0] n);
        int t;
        in_data  = d;
        in_lanes = n;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready0 && t < 200);
        if (t >= 200) chk("put_word_timeout", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy0 || busy1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_bound", 32'(t < 200), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_lanes  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_out_last",  32'(out_last0),  32'd0);
        chk("rst_out_data",  32'(out_data0),  32'd0);
        chk("rst_out_idx",   32'(out_idx0),   32'd0);
        chk("rst_busy",      32'(busy0),      32'd0);
        chk("rst_in_ready",  32'(in_ready0),  32'd1);
        chk("rst_idx_msb",   32'(out_idx1),   32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ascending order, full word, first beat one cycle after accept.
        out_ready = 1'b1;
        put_word(32'h4433_2211, 3'd4);
        @(negedge clk);
        chk("t1_latency_valid", 32'(out_valid0), 32'd1);
        chk("t1_first_data",    32'(out_data0),  32'h11);
        drain();

        // Two lanes: descending instance sends lanes 3 then 2.
        put_word(32'h4433_2211, 3'd2);
        @(negedge clk);
        chk("t2_msb_first_idx", 32'(out_idx1), 32'd3);
        drain();
        chk("t2_idle_ready", 32'(in_ready1), 32'd1);

        // Back-to-back words: no gap; in_ready only on last-beat cycles.
        put_word(32'hDDCC_BBAA, 3'd4);
        fork
            put_word(32'h4433_2211, 3'd4);
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    chk("t3_no_bubble", 32'(out_valid0), 32'd1);
                    chk("t3_in_ready",  32'(in_ready0),  32'((k % 4) == 3));
                end
            end
        join
        drain();

        // Stall on the second beat for three cycles.
        put_word(32'h4433_2211, 3'd4);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_data",     32'(out_data0), 32'h22);
            chk("t4_stall_idx",      32'(out_idx0),  32'd1);
            chk("t4_stall_in_ready", 32'(in_ready0), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Lane-count clamping and single-lane words.
        put_word(32'h4433_2211, 3'd0);
        drain();
        put_word(32'h4433_2211, 3'd7);
        drain();
        put_word(32'h4433_2211, 3'd1);
        @(negedge clk);
        chk("t5_single_last", 32'(out_last0), 32'd1);
        chk("t5_single_data", 32'(out_data0), 32'h11);
        drain();

        // Reset in the middle of a word discards the rest of it.
        put_word(32'h4433_2211, 3'd4);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid0", 32'(out_valid0), 32'd0);
        chk("t6_rst_valid1", 32'(out_valid1), 32'd0);
        chk("t6_rst_busy",   32'(busy0),      32'd0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_no_resume", 32'(out_valid0), 32'd0);
        end
        @(posedge clk);
        #1;
        put_word(32'h8877_6655, 3'd4);
        @(negedge clk);
        chk("t6_restart_idx",  32'(out_idx0),  32'd0);
        chk("t6_restart_data", 32'(out_data0), 32'h55);
        drain();

        // Randomised words, lane counts, gaps and downstream back-pressure.
        rdy_mode = 1'b1;
        for (int w = 0; w < 150; w++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            put_word($urandom, 3'($urandom_range(0, 7)));
        end
        @(posedge clk);
        #2;
        rdy_mode  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("end_queue0_empty", 32'(q0.size()), 32'd0);
        chk("end_queue1_empty", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #400000;
        nerr++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
